// File: rtl/xpb_if.sv
// Start/lookup bus between the XPB table generator and its users.
interface xpb_if #(
    parameter int unsigned WIDTH  = 1024,
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned NUM_CH = 1
) ();
    logic                      start;
    logic [WIDTH-1:0]          modulus;
    logic [WIDTH-1:0]          base;
    logic                      busy;
    logic                      done;
    logic                      err;
    logic                      ready;
    logic [NUM_CH-1:0]         lk_valid;
    logic [NUM_CH*IDX_W-1:0]   lk_idx;
    logic [NUM_CH-1:0]         rd_valid;
    logic [NUM_CH*WIDTH-1:0]   rd_data;

    modport master (
        output start, modulus, base, lk_valid, lk_idx,
        input  busy, done, err, ready, rd_valid, rd_data
    );

    modport slave (
        input  start, modulus, base, lk_valid, lk_idx,
        output busy, done, err, ready, rd_valid, rd_data
    );
endinterface

// File: rtl/xpb_table_gen.sv
// Builds T[j] = j*B mod M one entry per cycle, then serves 1-cycle lookups
// on NUM_CH independent channels.
module xpb_table_gen #(
    parameter int unsigned WIDTH  = 1024,
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned NUM_CH = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    xpb_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {S_IDLE, S_GEN} state_e;

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        mod_q, mod_d;
    logic [WIDTH-1:0]        base_q, base_d;
    logic [WIDTH-1:0]        acc_q, acc_d;
    logic [IDX_W-1:0]        j_q, j_d;
    logic [WIDTH-1:0]        tbl_q [DEPTH];
    logic [WIDTH-1:0]        tbl_d [DEPTH];
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    ready_q, ready_d;
    logic [NUM_CH-1:0]       rd_valid_q, rd_valid_d;
    logic [NUM_CH*WIDTH-1:0] rd_data_q, rd_data_d;

    logic [WIDTH:0]          sum;
    logic [WIDTH:0]          diff;
    logic [WIDTH-1:0]        next_entry;

    // One modular-add step: acc + B with a single conditional subtract of M.
    always_comb begin
        sum        = {1'b0, acc_q} + {1'b0, base_q};
        diff       = sum - {1'b0, mod_q};
        next_entry = (sum >= {1'b0, mod_q}) ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
    end

    // Next-state for the generator FSM, table writes and lookup responses.
    always_comb begin
        state_d    = state_q;
        mod_d      = mod_q;
        base_d     = base_q;
        acc_d      = acc_q;
        j_d        = j_q;
        tbl_d      = tbl_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        ready_d    = ready_q;
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;

        // Reads use pre-edge ready and table, so a lookup coincident with
        // start still returns the old entry.
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (bus.lk_valid[c] && ready_q) begin
                rd_valid_d[c]                = 1'b1;
                rd_data_d[c*WIDTH +: WIDTH]  = tbl_q[bus.lk_idx[c*IDX_W +: IDX_W]];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mod_d   = bus.modulus;
                    base_d  = bus.base;
                    ready_d = 1'b0;
                    if (bus.base >= bus.modulus) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d    = 1'b0;
                        tbl_d[0] = '0;
                        acc_d    = '0;
                        j_d      = IDX_W'(1);
                        busy_d   = 1'b1;
                        state_d  = S_GEN;
                    end
                end
            end
            S_GEN: begin
                tbl_d[j_q] = next_entry;
                acc_d      = next_entry;
                j_d        = j_q + IDX_W'(1);
                if (j_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts generation and clears the table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mod_q      <= '0;
            base_q     <= '0;
            acc_q      <= '0;
            j_q        <= '0;
            for (int i = 0; i < int'(DEPTH); i++) tbl_q[i] <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            mod_q      <= mod_d;
            base_q     <= base_d;
            acc_q      <= acc_d;
            j_q        <= j_d;
            tbl_q      <= tbl_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.ready    = ready_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed bench: a small 16-bit two-channel instance and a full 1024-bit instance.
module tb_xpb_table_gen;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    xpb_if #(.WIDTH(16),   .IDX_W(3), .NUM_CH(2)) a ();
    xpb_if #(.WIDTH(1024), .IDX_W(5), .NUM_CH(1)) b ();

    xpb_table_gen #(.WIDTH(16),   .IDX_W(3), .NUM_CH(2)) u_small (.clk(clk), .rst_n(rst_n), .bus(a));
    xpb_table_gen #(.WIDTH(1024), .IDX_W(5), .NUM_CH(1)) u_big   (.clk(clk), .rst_n(rst_n), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (low 64 bits)", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the start edge until done; optionally re-pulses start mid-GEN.
    task automatic wait_done_small(input bit inject, output int n);
        n = 0;
        while (!a.done && n < 50) begin
            if (inject && n == 3) begin
                a.start   = 1'b1;
                a.base    = 16'h0002;
                a.lk_valid = 2'b01;
            end
            step();
            a.start    = 1'b0;
            a.lk_valid = 2'b00;
            if (inject && n == 3) check("mid_gen_lookup_dropped", 1024'(a.rd_valid), 1024'(2'b00));
            n++;
        end
    endtask

    logic [15:0]   exp1 [8];
    logic [1023:0] big_m, big_b;
    logic [1023:0] gold [32];
    logic [1055:0] prod;
    int            n;

    initial begin
        checks = 0;
        failures = 0;
        exp1 = '{16'h0000, 16'h8000, 16'h000F, 16'h800F, 16'h001E, 16'h801E, 16'h002D, 16'h802D};
        a.start = 1'b0; a.modulus = '0; a.base = '0; a.lk_valid = '0; a.lk_idx = '0;
        b.start = 1'b0; b.modulus = '0; b.base = '0; b.lk_valid = '0; b.lk_idx = '0;
        rst_n = 1'b0;
        #12;
        check("reset_busy",  1024'(a.busy), 1024'(0));
        check("reset_done",  1024'(a.done), 1024'(0));
        check("reset_err",   1024'(a.err), 1024'(0));
        check("reset_ready", 1024'(a.ready), 1024'(0));
        check("reset_rdv",   1024'(a.rd_valid), 1024'(0));
        check("reset_rdd",   1024'(a.rd_data), 1024'(0));
        rst_n = 1'b1;
        step();

        // Small-width generation
        a.modulus = 16'hFFF1; a.base = 16'h8000; a.start = 1'b1;
        step();
        a.start = 1'b0;
        check("gen_busy_at_start", 1024'(a.busy), 1024'(1));
        check("gen_ready_at_start", 1024'(a.ready), 1024'(0));
        wait_done_small(1'b0, n);
        check("gen_cycles", 1024'(n), 1024'(7));
        check("gen_ready", 1024'(a.ready), 1024'(1));
        check("gen_busy_fell", 1024'(a.busy), 1024'(0));
        check("gen_err", 1024'(a.err), 1024'(0));

        // Back-to-back lookups on both channels, ch1 reads in reverse order
        for (int i = 0; i < 8; i++) begin
            a.lk_valid = 2'b11;
            a.lk_idx   = {3'(7 - i), 3'(i)};
            step();
            check("lk_valid_both", 1024'(a.rd_valid), 1024'(2'b11));
            check("lk_ch0", 1024'(a.rd_data[15:0]), 1024'(exp1[i]));
            check("lk_ch1", 1024'(a.rd_data[31:16]), 1024'(exp1[7 - i]));
            if (i == 0) check("done_single_pulse", 1024'(a.done), 1024'(0));
        end
        a.lk_idx = {3'd3, 3'd3}; a.lk_valid = 2'b11;
        step();
        check("shared_ch0", 1024'(a.rd_data[15:0]), 1024'(16'h800F));
        check("shared_ch1", 1024'(a.rd_data[31:16]), 1024'(16'h800F));
        a.lk_idx = {3'd0, 3'd7};
        step();
        check("b2b_ch0", 1024'(a.rd_data[15:0]), 1024'(16'h802D));
        check("b2b_ch1", 1024'(a.rd_data[31:16]), 1024'(16'h0000));
        check("b2b_valid", 1024'(a.rd_valid), 1024'(2'b11));
        a.lk_valid = 2'b00;
        step();
        check("idle_rdv", 1024'(a.rd_valid), 1024'(0));
        check("idle_hold", 1024'(a.rd_data[15:0]), 1024'(16'h802D));

        // Regeneration with a coincident lookup, plus an ignored mid-GEN start
        a.modulus = 16'hFFF1; a.base = 16'h0001; a.start = 1'b1;
        a.lk_valid = 2'b01; a.lk_idx = {3'd0, 3'd1};
        step();
        a.start = 1'b0; a.lk_valid = 2'b00;
        check("regen_old_entry", 1024'(a.rd_data[15:0]), 1024'(16'h8000));
        check("regen_old_valid", 1024'(a.rd_valid), 1024'(2'b01));
        check("regen_ready_drop", 1024'(a.ready), 1024'(0));
        check("regen_busy", 1024'(a.busy), 1024'(1));
        wait_done_small(1'b1, n);
        check("regen_cycles", 1024'(n), 1024'(7));
        for (int i = 0; i < 8; i++) begin
            a.lk_valid = 2'b10;
            a.lk_idx   = {3'(i), 3'd0};
            step();
            check("regen_tj", 1024'(a.rd_data[31:16]), 1024'(i));
        end
        a.lk_valid = 2'b00;

        // Error path: B >= M
        a.modulus = 16'h0100; a.base = 16'h0100; a.start = 1'b1;
        step();
        a.start = 1'b0;
        check("err_flag", 1024'(a.err), 1024'(1));
        check("err_done", 1024'(a.done), 1024'(1));
        check("err_busy", 1024'(a.busy), 1024'(0));
        check("err_ready", 1024'(a.ready), 1024'(0));
        a.lk_valid = 2'b11;
        step();
        a.lk_valid = 2'b00;
        check("err_done_pulse", 1024'(a.done), 1024'(0));
        check("err_held", 1024'(a.err), 1024'(1));
        check("err_busy2", 1024'(a.busy), 1024'(0));
        check("err_lookup_dropped", 1024'(a.rd_valid), 1024'(0));

        // Reset mid-GEN
        a.modulus = 16'hFFF1; a.base = 16'h0003; a.start = 1'b1;
        step();
        a.start = 1'b0;
        step(); step(); step();
        check("pre_reset_busy", 1024'(a.busy), 1024'(1));
        rst_n = 1'b0;
        #1;
        check("async_busy", 1024'(a.busy), 1024'(0));
        check("async_ready", 1024'(a.ready), 1024'(0));
        check("async_done", 1024'(a.done), 1024'(0));
        check("async_err", 1024'(a.err), 1024'(0));
        check("async_rdd", 1024'(a.rd_data), 1024'(0));
        #2;
        rst_n = 1'b1;
        step();
        check("post_reset_done", 1024'(a.done), 1024'(0));
        a.start = 1'b1;
        step();
        a.start = 1'b0;
        wait_done_small(1'b0, n);
        check("post_reset_cycles", 1024'(n), 1024'(7));
        a.lk_valid = 2'b01; a.lk_idx = {3'd0, 3'd5};
        step();
        a.lk_valid = 2'b00;
        check("post_reset_t5", 1024'(a.rd_data[15:0]), 1024'(16'h000F));

        // Full-width random table
        for (int w = 0; w < 32; w++) begin
            big_m[w*32 +: 32] = $urandom();
            big_b[w*32 +: 32] = $urandom();
        end
        big_m[0] = 1'b1;
        big_m[1023] = 1'b1;
        if (big_b >= big_m) big_b = big_b - big_m;
        for (int j = 0; j < 32; j++) begin
            prod = 1056'(j) * {32'b0, big_b};
            prod = prod % {32'b0, big_m};
            gold[j] = prod[1023:0];
        end
        b.modulus = big_m; b.base = big_b; b.start = 1'b1;
        step();
        b.start = 1'b0;
        n = 0;
        while (!b.done && n < 100) begin
            step();
            n++;
        end
        check("big_cycles", 1024'(n), 1024'(31));
        check("big_ready", 1024'(b.ready), 1024'(1));
        for (int j = 0; j < 32; j++) begin
            b.lk_valid = 1'b1;
            b.lk_idx   = 5'(j);
            step();
            check("big_entry", b.rd_data, gold[j]);
            check("big_lt_m", 1024'(b.rd_data < big_m), 1024'(1));
        end
        b.lk_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xpb_table_gen.md
# xpb_table_gen

Runtime-generated XPB lookup table for the modular squaring datapath. On `start` it builds T[j] = j·B mod M for j = 0..2^IDX_W−1 by iterative modular addition, with one entry per cycle, and stores the table in internal registers. It then serves single-cycle-latency lookups on NUM_CH independent channels. It replaces the fixed per-segment constant ROMs, so the modulus and shift base can change without resynthesis.

## Interface
- WIDTH, 1024, modulus/entry width in bits
- IDX_W, 5, index width; table depth is 2^IDX_W
- NUM_CH, 1, number of parallel lookup channels
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin generation; sampled only when not busy
- modulus  in  WIDTH  M, latched at the start edge
- base  in  WIDTH  B (= 2^s mod M, supplied by the caller), latched at the start edge
- busy  out  1  generation in progress
- done  out  1  one-cycle pulse at the end of generation or on an error
- err  out  1  B ≥ M detected at the last start; held until the next accepted start
- ready  out  1  table is valid for lookups
- lk_valid  in  NUM_CH  per-channel lookup request
- lk_idx  in  NUM_CH·IDX_W  channel c index in bits [c·IDX_W +: IDX_W]
- rd_valid  out  NUM_CH  per-channel response valid
- rd_data  out  NUM_CH·WIDTH  channel c entry in bits [c·WIDTH +: WIDTH]

## Operation
- **States.** IDLE, GEN.
- **Reset values.** All outputs are 0. Table contents, accumulator, counter and latched M/B are cleared. The state is IDLE.
- **IDLE + start.**
  - M and B are latched.
  - If B ≥ M: err←1, done←1 for one cycle, ready←0. The state stays IDLE.
  - Otherwise: err←0, ready←0, T[0]←0, acc←0, j←1, busy←1, and the state goes to GEN.
- **GEN, each cycle.**
  - s = acc + B, computed as WIDTH+1 bits.
  - r = (s ≥ M) ? s − M : s[WIDTH−1:0].
  - T[j]←r, acc←r, j←j+1.
- **GEN, last write.** When j = 2^IDX_W−1 is written:
  - busy←0, done←1, ready←1.
  - The state goes to IDLE.
- **Invariant.** Since B < M and acc < M, a single conditional subtract is sufficient. All entries are < M.
- **Start while busy.** Ignored; M and B are not re-latched.
- **Start while ready.** Regenerates the table. ready drops on the start edge, and the old contents are not readable after that edge.
- **Lookup.** For each channel independently, if lk_valid[c] && ready:
  - rd_valid[c]←1, rd_data[c]←T[lk_idx[c]] on the next edge.
  - Otherwise rd_valid[c]←0 and rd_data[c] holds its previous value.
  - Requests made while not ready are dropped, not queued.
- **Shared index.** Multiple channels may read the same index in the same cycle.
- **Simultaneous lookup and start (ready=1).** The lookup on that edge returns the old entry, because reads are sampled against the pre-edge ready. Later lookups are dropped until regeneration completes.
- **rst_n low mid-GEN.** Generation aborts immediately. ready=0 and busy=0, and the table is cleared. No done pulse is produced.

## Timing
- **Generation.** Start is sampled at edge t. busy is high from t to t+2^IDX_W−1. done and ready rise, and busy falls, at edge t+2^IDX_W−1. Total: 2^IDX_W−1 cycles.
- **Error path.** done and err rise at edge t; busy never asserts.
- **Lookup latency.** 1 cycle: request at edge k, data and rd_valid at edge k+1. Throughput is one lookup per channel per cycle.
- **Critical path.** One WIDTH-bit add, one WIDTH-bit compare/subtract and a mux per cycle. Internal pipelining is not permitted; the one-entry-per-cycle contract is fixed.

## Test plan
- **Small-width generation.** WIDTH=16, IDX_W=3, M=0xFFF1, B=0x8000 → after 7 busy cycles, done pulses once and ready=1. Lookups of 0..7 return 0x0000, 0x8000, 0x000F, 0x800F, 0x001E, 0x801E, 0x002D, 0x802D.
- **Error path.** M=0x0100, B=0x0100 → err=1, done for one cycle at the start edge, busy never high, ready stays 0, and lookups give rd_valid=0.
- **Regeneration and ignored start.**
  - After the table is valid, start with B=0x0001 and M=0xFFF1 → ready drops at the start edge, and the later table has T[j]=j.
  - A second start pulsed mid-GEN is ignored (cycle count unchanged).
- **Multi-channel.** NUM_CH=2 with back-to-back lookups (ch0 idx 3, ch1 idx 3; then ch0 7, ch1 0) → both channels return the correct entries at latency 1, every cycle.
- **Reset mid-operation.** Assert rst_n=0 at GEN cycle 4 → all outputs are 0 asynchronously. After release, a new start completes normally and no stale done pulse appears.
- **Full-width check.** WIDTH=1024, IDX_W=5, random 1024-bit odd M with random B<M → all 32 entries match a golden j·B mod M model, done appears 31 cycles after start, and every entry is < M.
